// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared UART definitions (drain FSM states, data width)  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int unsigned UART_DW = 8;

    // Drain FSM encoding; the transmitter and receiver share this width
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo_if : producer/status/transmitter bundle of the FIFO   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DW = UART_DW,
    parameter int unsigned AW = 4
);
    logic          push_en;
    logic [DW-1:0] push_data;
    logic          flush;
    logic          clr_ovf;
    logic          full;
    logic          afull;
    logic [AW:0]   level;
    logic          ovf;
    logic          snd_wen;
    logic [DW-1:0] snd_din;
    logic          snd_rdy;

    // slave is the FIFO itself; master is the producer/transmitter side
    modport slave (
        input  push_en, push_data, flush, clr_ovf, snd_rdy,
        output full, afull, level, ovf, snd_wen, snd_din
    );

    modport master (
        output push_en, push_data, flush, clr_ovf, snd_rdy,
        input  full, afull, level, ovf, snd_wen, snd_din
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_fifo_mem : dual-port array, synchronous write / async read    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DW = UART_DW,
    parameter int unsigned AW = 4
) (
    input  wire logic          CLK,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic [AW-1:0] i_raddr,
    output logic      [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo : byte queue feeding the UART transmitter handshake   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DW       = UART_DW,
    parameter int unsigned AW       = 4,
    parameter int unsigned AFULL_TH = 12
) (
    input  wire logic      CLK,
    input  wire logic      RST_X,
    uart_tx_fifo_if.slave  io_bus
);
    localparam logic [AW:0] c_AFULL_TH = AFULL_TH[AW:0];
    localparam logic [AW:0] c_PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_ovf;
    logic          r_snd_wen;
    logic [DW-1:0] r_snd_din;
    logic [1:0]    r_state;

    logic [AW:0]   w_level;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic [DW-1:0] w_rdata;

    // Flags come only from registered pointers, so no input-to-flag paths
    assign w_level = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

    assign w_push = io_bus.push_en & ~w_full & ~io_bus.flush;
    assign w_drop = io_bus.push_en &  w_full & ~io_bus.flush;
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty & io_bus.snd_rdy & ~io_bus.flush;

    uart_fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_push),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (io_bus.push_data),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (io_bus.flush) begin
                r_rptr <= r_wptr;
            end else if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (io_bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // GUARD spans the cycle where the transmitter's rdy is still falling
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state   <= ST_IDLE;
            r_snd_wen <= 1'b0;
            r_snd_din <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_snd_din <= w_rdata;
                        r_snd_wen <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_snd_wen <= 1'b0;
                    r_state   <= ST_GUARD;
                end
                ST_GUARD: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_snd_wen <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.full    = w_full;
    assign io_bus.afull   = (w_level >= c_AFULL_TH);
    assign io_bus.level   = w_level;
    assign io_bus.ovf     = r_ovf;
    assign io_bus.snd_wen = r_snd_wen;
    assign io_bus.snd_din = r_snd_din;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx_fifo : scoreboard bench for uart_tx_fifo                |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_uart_tx_fifo;
    localparam int unsigned c_DW = 8;
    localparam int unsigned c_AW = 4;

    logic clk;
    logic rst_x;
    logic model_en;
    logic man_rdy;
    int   busy;
    int   n_cmp;
    int   n_bad;
    int   n_issued;
    logic [7:0] sb[$];

    uart_tx_fifo_if #(.DW(c_DW), .AW(c_AW)) bus ();

    uart_tx_fifo #(
        .DW       (c_DW),
        .AW       (c_AW),
        .AFULL_TH (12)
    ) dut (
        .CLK    (clk),
        .RST_X  (rst_x),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.snd_rdy = model_en ? (busy == 0) : man_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit expect_out);
        bus.push_en   = 1'b1;
        bus.push_data = d;
        if (expect_out) sb.push_back(d);
        tick();
        bus.push_en = 1'b0;
    endtask

    // Transmitter model: rdy drops the cycle after wen and stays low 20 cycles
    initial begin
        logic saw;
        busy = 0;
        forever begin
            @(negedge clk);
            saw = bus.snd_wen;
            @(posedge clk);
            #1;
            if (saw) busy = 20;
            else if (busy > 0) busy = busy - 1;
        end
    end

    // Monitor: every issued byte is popped from the scoreboard and compared
    initial begin
        logic prev_wen;
        logic prev_rdy;
        logic [7:0] exp_b;
        prev_wen = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.snd_wen === 1'b1) begin
                n_issued++;
                check("wen_single_cycle", {31'd0, prev_wen}, 32'd0);
                check("wen_only_when_rdy", {31'd0, prev_rdy}, 32'd1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_issue: got din 0x%0h expected no issue at %0t", bus.snd_din, $time);
                end else begin
                    exp_b = sb.pop_front();
                    check("snd_din", {24'd0, bus.snd_din}, {24'd0, exp_b});
                end
            end
            prev_wen = bus.snd_wen;
            prev_rdy = bus.snd_rdy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; n_issued = 0;
        rst_x = 1'b0; model_en = 1'b0; man_rdy = 1'b0;
        bus.push_en = 1'b0; bus.push_data = '0; bus.flush = 1'b0; bus.clr_ovf = 1'b0;
        tick(); tick();
        check("rst_level", {27'd0, bus.level}, 32'd0);
        check("rst_full", {31'd0, bus.full}, 32'd0);
        check("rst_afull", {31'd0, bus.afull}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst_wen", {31'd0, bus.snd_wen}, 32'd0);
        check("rst_din", {24'd0, bus.snd_din}, 32'd0);
        rst_x = 1'b1;
        tick();

        // Reset mid-burst discards queued bytes
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b0);
        check("burst_level", {27'd0, bus.level}, 32'd3);
        rst_x = 1'b0;
        #1;
        check("midrst_level", {27'd0, bus.level}, 32'd0);
        tick();
        rst_x = 1'b1;
        man_rdy = 1'b1;
        repeat (6) tick();
        check("postrst_level", {27'd0, bus.level}, 32'd0);
        check("postrst_no_issue", n_issued, 32'd0);

        // Single byte: level 1 then 0, wen two cycles after push
        push_byte(8'hA5, 1'b1);
        check("single_level1", {27'd0, bus.level}, 32'd1);
        check("single_wen_t1", {31'd0, bus.snd_wen}, 32'd0);
        tick();
        check("single_wen_t2", {31'd0, bus.snd_wen}, 32'd1);
        check("single_din_t2", {24'd0, bus.snd_din}, 32'hA5);
        check("single_level0", {27'd0, bus.level}, 32'd0);
        tick();
        check("single_wen_t3", {31'd0, bus.snd_wen}, 32'd0);
        repeat (3) tick();

        // Fill to full with the transmitter stalled
        man_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_byte(i[7:0], 1'b1);
            if (i == 10) check("afull_at_11", {31'd0, bus.afull}, 32'd0);
            if (i == 11) check("afull_at_12", {31'd0, bus.afull}, 32'd1);
            if (i == 14) check("full_at_15", {31'd0, bus.full}, 32'd0);
        end
        check("fill_full", {31'd0, bus.full}, 32'd1);
        check("fill_level", {27'd0, bus.level}, 32'd16);
        check("fill_ovf0", {31'd0, bus.ovf}, 32'd0);
        push_byte(8'hEE, 1'b0);
        check("ovf_set", {31'd0, bus.ovf}, 32'd1);
        check("ovf_level", {27'd0, bus.level}, 32'd16);

        // Overflow and clear in the same cycle: set wins
        bus.clr_ovf = 1'b1;
        push_byte(8'hEF, 1'b0);
        bus.clr_ovf = 1'b0;
        check("ovf_set_wins", {31'd0, bus.ovf}, 32'd1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", {31'd0, bus.ovf}, 32'd0);

        // Drain through the transmitter model
        model_en = 1'b1;
        for (int i = 0; i < 2000 && (sb.size() != 0 || bus.level != 0); i++) tick();
        repeat (4) tick();
        check("drain_done", sb.size(), 32'd0);
        check("drain_level", {27'd0, bus.level}, 32'd0);
        check("drain_count", n_issued, 32'd17);

        // Flush while issuing: current byte completes, rest discarded
        model_en = 1'b0;
        man_rdy  = 1'b0;
        repeat (25) tick();
        push_byte(8'h50, 1'b1);
        for (int i = 1; i < 6; i++) push_byte(8'h50 + i[7:0], 1'b0);
        man_rdy = 1'b1;
        tick();
        check("flush_in_issue", {31'd0, bus.snd_wen}, 32'd1);
        check("flush_pre_level", {27'd0, bus.level}, 32'd5);
        bus.flush = 1'b1;
        push_byte(8'h77, 1'b0);
        bus.flush = 1'b0;
        check("flush_level", {27'd0, bus.level}, 32'd0);
        check("flush_no_ovf", {31'd0, bus.ovf}, 32'd0);
        check("flush_guard_wen", {31'd0, bus.snd_wen}, 32'd0);
        repeat (8) tick();
        check("flush_after_level", {27'd0, bus.level}, 32'd0);
        check("flush_sb_empty", sb.size(), 32'd0);
        check("flush_issue_count", n_issued, 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer that sits directly upstream of the UART transmitter and feeds its `wen`/`din`/`rdy` byte interface. It accepts bursts of bytes from a producer (CPU bus bridge, logger, test pattern source) at clock rate. It drains them one at a time to the transmitter through a registered handshake that never double-issues. It also reports fill level, almost-full and a sticky overflow flag.

## Interface
- `DW`, 8: data width, equal to the transmitter's `DW`.
- `AW`, 4: address width; depth = 2^AW entries.
- `AFULL_TH`, 12: `afull` asserts when `level >= AFULL_TH`; legal range 1..2^AW.

- `CLK`  in  1  clock.
- `RST_X`  in  1  asynchronous reset, active-low.
- `push_en`  in  1  write strobe; one byte per cycle.
- `push_data`  in  DW  byte to enqueue.
- `flush`  in  1  synchronous clear of queue contents.
- `clr_ovf`  in  1  clears `ovf`.
- `full`  out  1  queue holds 2^AW entries.
- `afull`  out  1  level at or above threshold.
- `level`  out  AW+1  current entry count, 0..2^AW.
- `ovf`  out  1  sticky: a push was dropped because the queue was full.
- `snd_wen`  out  1  to transmitter `wen`; registered.
- `snd_din`  out  DW  to transmitter `din`; registered, valid while `snd_wen`=1.
- `snd_rdy`  in  1  from transmitter `rdy`.

## Operation
- Storage: 2^AW x DW array. Pointers `wptr`/`rptr` are AW+1 bits wide and wrap modulo 2^(AW+1).
- Empty when `wptr == rptr`. Full when the low AW bits are equal and the MSBs differ. `level = wptr - rptr` (AW+1-bit modular).
- Push accepted iff `push_en & ~full & ~flush`. The byte is written at `mem[wptr[AW-1:0]]` and `wptr` increments.
- `push_en & full & ~flush` drops the byte and sets `ovf`. `full` is evaluated before any same-cycle pop, so a push into a full queue is dropped even if a pop occurs that cycle.
- `ovf`: a set in the same cycle as `clr_ovf` wins.
- `flush`: sets `rptr <= wptr` (queue empties next cycle) and suppresses any same-cycle push and pop. It does not abort an issue already in progress, and it does not set `ovf`.
- Drain FSM has three states:
  - IDLE: if `~empty & snd_rdy & ~flush`, load `snd_din <= mem[rptr]`, increment `rptr`, set `snd_wen <= 1`, and go to ISSUE.
  - ISSUE: `snd_wen` is 1 for exactly this one cycle. Set `snd_wen <= 0` and go to GUARD.
  - GUARD: one cycle with `snd_wen`=0, covering the cycle where the transmitter's `rdy` is still falling. Then go to IDLE.
- Unused encodings return to IDLE.
- No IDLE→ISSUE transition is permitted while `snd_rdy`=0. The transmitter's `rdy` is low for the whole frame, and also after its own reset until its first idle frame completes; the block must simply wait.
- Simultaneous push and pop on a non-full queue: both take effect and `level` is unchanged.
- `snd_din` holds its last value when `snd_wen`=0.

## Timing
- Reset values: `full`=0, `afull`=0, `level`=0, `ovf`=0, `snd_wen`=0, `snd_din`=0, FSM=IDLE, both pointers 0.
- Push in cycle t: `level`/`full`/`afull` update in t+1.
- First-byte latency: push into an empty queue at t with `snd_rdy`=1 gives `snd_wen`=1 in t+2.
- Back-to-back issue interval is at least 3 cycles (IDLE, ISSUE, GUARD). In practice it is bounded by the transmitter frame time: `(DW+2)` bit periods.
- `full`, `afull`, `level`, `ovf` are registered or derived only from registered pointers; there are no combinational paths from inputs.

## Structure
- Shared package `uart_pkg`: drain FSM state encoding (IDLE, ISSUE, GUARD) and the default `DW`. The transmitter and the future receiver import the same package.
- One sub-module, `uart_fifo_mem`: simple dual-port array with synchronous write and asynchronous read, parameterised by `DW`/`AW`. Pointer, flag and FSM logic stay in `uart_tx_fifo`.

## Test plan
- Reset mid-burst: push 3 bytes, assert `RST_X` low for 1 cycle → all outputs return to reset values; no `snd_wen` after release until a new push.
- Single byte 0xA5 pushed with `snd_rdy`=1 → `snd_wen`=1 for exactly one cycle two cycles after push, with `snd_din`=0xA5; `level` goes 1 then 0.
- Push 16 bytes 0x00..0x0F (AW=4) with `snd_rdy`=0 → `full`=1, `level`=16, `afull` from level 12. A 17th push sets `ovf`=1 and `level` stays 16.
- Release `snd_rdy` with a behavioural transmitter model (`rdy` low 20 cycles after each `wen`) → bytes emerge 0x00..0x0F in order; `snd_wen` never asserted while `snd_rdy`=0; no duplicates.
- `flush` with 5 entries queued while in ISSUE → the current byte still issues once; `level`=0 the next cycle; a `push_en` in the flush cycle is dropped without setting `ovf`.
- `clr_ovf` and an overflowing push in the same cycle → `ovf` remains 1; `clr_ovf` alone next cycle → `ovf`=0.
